// File: rtl/fft_sdf_bf_stage.sv
// fft_sdf_bf_stage
// Radix-2 DIF single-path delay-feedback butterfly stage (first stage of a
// 32-point FFT). The stage pairs sample n with sample n+16 through a DEPTH-deep
// feedback delay line. It emits 16 sums during the butterfly phase and
// 16 twiddle-multiplied differences during the drain phase.
//
// Ports:
//   clk, reset       - clock; asynchronous active-high reset
//   in_valid         - din_r/din_i valid this cycle
//   din_r, din_i     - signed complex input sample
//   state            - phase from the twiddle ROM: 0 fill, 1 butterfly,
//                      2 drain/twiddle, 3 idle
//   w_r, w_i         - signed Q.FRAC twiddle, applied to the delay-line head
//   dout_r, dout_i   - registered complex output
//   out_valid        - registered output strobe
//   out_idx          - registered index (0..31) of the output within the frame
module fft_sdf_bf_stage #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 24,
    parameter int unsigned FRAC  = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] din_r,
    input  logic [DW-1:0] din_i,
    input  logic [1:0]    state,
    input  logic [DW-1:0] w_r,
    input  logic [DW-1:0] w_i,
    output logic [DW-1:0] dout_r,
    output logic [DW-1:0] dout_i,
    output logic          out_valid,
    output logic [4:0]    out_idx
);

    typedef enum logic [1:0] {
        PH_FILL  = 2'd0,
        PH_BFLY  = 2'd1,
        PH_DRAIN = 2'd2,
        PH_IDLE  = 2'd3
    } phase_t;

    phase_t phase;
    assign phase = phase_t'(state);

    // Delay line; index 0 is the head (oldest entry).
    logic [DW-1:0] dl_r [DEPTH];
    logic [DW-1:0] dl_i [DEPTH];

    logic [DW-1:0] head_r, head_i;
    assign head_r = dl_r[0];
    assign head_i = dl_i[0];

    // Index the next emitted output will carry.
    logic [4:0] next_idx;

    // Full-width complex multiply of the head by the twiddle.
    logic signed [2*DW-1:0] hr_x, hi_x, wr_x, wi_x;
    logic signed [2*DW-1:0] acc_r, acc_i;
    logic        [DW-1:0]   tw_r, tw_i;

    always_comb begin
        hr_x  = {{DW{head_r[DW-1]}}, head_r};
        hi_x  = {{DW{head_i[DW-1]}}, head_i};
        wr_x  = {{DW{w_r[DW-1]}}, w_r};
        wi_x  = {{DW{w_i[DW-1]}}, w_i};
        acc_r = hr_x * wr_x - hi_x * wi_x;
        acc_i = hr_x * wi_x + hi_x * wr_x;
        tw_r  = DW'(acc_r >>> FRAC);
        tw_i  = DW'(acc_i >>> FRAC);
    end

    logic          shift;
    logic          emit;
    logic [DW-1:0] push_r, push_i;
    logic [DW-1:0] res_r, res_i;

    always_comb begin
        shift  = 1'b0;
        emit   = 1'b0;
        push_r = '0;
        push_i = '0;
        res_r  = '0;
        res_i  = '0;
        case (phase)
            PH_FILL: begin
                if (in_valid) begin
                    shift  = 1'b1;
                    push_r = din_r;
                    push_i = din_i;
                end
            end
            PH_BFLY: begin
                if (in_valid) begin
                    shift  = 1'b1;
                    emit   = 1'b1;
                    push_r = head_r - din_r;
                    push_i = head_i - din_i;
                    res_r  = head_r + din_r;
                    res_i  = head_i + din_i;
                end
            end
            PH_DRAIN: begin
                // Drain runs every cycle regardless of in_valid and
                // back-fills the line with zeros.
                shift = 1'b1;
                emit  = 1'b1;
                res_r = tw_r;
                res_i = tw_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                dl_r[i] <= '0;
                dl_i[i] <= '0;
            end
        end else if (shift) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                dl_r[i] <= dl_r[i+1];
                dl_i[i] <= dl_i[i+1];
            end
            dl_r[DEPTH-1] <= push_r;
            dl_i[DEPTH-1] <= push_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_r    <= '0;
            dout_i    <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            next_idx  <= '0;
        end else begin
            out_valid <= emit;
            if (emit) begin
                dout_r   <= res_r;
                dout_i   <= res_i;
                out_idx  <= next_idx;
                next_idx <= next_idx + 5'd1;
            end else if (phase == PH_FILL) begin
                out_idx  <= '0;
                next_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fft_sdf_bf_stage.sv
// tb_fft_sdf_bf_stage
// Table-driven bench for fft_sdf_bf_stage. Each frame is expanded into
// per-cycle records of {state, in_valid, din, twiddle, expected outputs}.
// Expected outputs come from a direct butterfly formula:
//   out[k]    = x[k] + x[k+16]
//   out[16+k] = ((x[k] - x[k+16]) * w^k) >>> 8
// A hand-written sequence covers an asynchronous reset mid-frame.
module tb_fft_sdf_bf_stage;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] din_r = '0, din_i = '0;
    logic [1:0]    state = 2'd3;
    logic [DW-1:0] w_r = '0, w_i = '0;
    logic [DW-1:0] dout_r, dout_i;
    logic          out_valid;
    logic [4:0]    out_idx;

    fft_sdf_bf_stage #(.DEPTH(16), .DW(DW), .FRAC(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .din_r(din_r), .din_i(din_i), .state(state),
        .w_r(w_r), .w_i(w_i),
        .dout_r(dout_r), .dout_i(dout_i),
        .out_valid(out_valid), .out_idx(out_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]    st;
        logic          v;
        logic [DW-1:0] xr, xi, wr, wi;
        logic          ev;
        logic [DW-1:0] er, ei;
        logic [4:0]    eidx;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d): got %0h, want %0h", name, id, act, exp);
        end
    endtask

    // Rounded 256*cos(2*pi*k/32) for k = 0..8.
    function automatic int cq(input int k);
        case (k)
            0: return 256;
            1: return 251;
            2: return 237;
            3: return 213;
            4: return 181;
            5: return 142;
            6: return 98;
            7: return 50;
            default: return 0;
        endcase
    endfunction

    // w^k = exp(-j*2*pi*k/32) in Q.8, k = 0..15.
    function automatic int twr(input int k);
        return (k <= 8) ? cq(k) : -cq(16 - k);
    endfunction

    function automatic int twi(input int k);
        return (k <= 8) ? -cq(8 - k) : -cq(k - 8);
    endfunction

    function automatic vec_t mk(input logic [1:0] st, input logic v,
                                input logic [DW-1:0] xr, input logic [DW-1:0] xi);
        vec_t r;
        r.st = st; r.v = v; r.xr = xr; r.xi = xi;
        r.wr = DW'($urandom); r.wi = DW'($urandom);
        r.ev = 1'b0; r.er = '0; r.ei = '0; r.eidx = '0;
        return r;
    endfunction

    task automatic add_frame(input int pat, input bit gaps);
        logic [DW-1:0] xr[32];
        logic [DW-1:0] xi[32];
        logic [DW-1:0] dr, di;
        longint        sr, si, lwr, lwi, ar, ai;
        vec_t          v;
        for (int n = 0; n < 32; n++) begin
            xr[n] = '0;
            xi[n] = '0;
        end
        case (pat)
            0: xr[0] = 24'd256;
            1: for (int n = 0; n < 32; n++) xr[n] = 24'd256;
            2: for (int n = 0; n < 16; n++) xr[n] = 24'd256;
            3: begin
                xr[0]  = 24'h7FFFFF;
                xr[16] = 24'd1;
            end
            default: for (int n = 0; n < 32; n++) begin
                xr[n] = DW'(n * 10 - 100);
                xi[n] = DW'(3 * n + 5);
            end
        endcase
        for (int n = 0; n < 16; n++) begin
            if (gaps && n == 5)
                for (int g = 0; g < 3; g++)
                    vecs.push_back(mk(2'd0, 1'b0, DW'($urandom), DW'($urandom)));
            vecs.push_back(mk(2'd0, 1'b1, xr[n], xi[n]));
        end
        for (int k = 0; k < 16; k++) begin
            if (gaps && k == 4)
                for (int g = 0; g < 2; g++)
                    vecs.push_back(mk(2'd1, 1'b0, DW'($urandom), DW'($urandom)));
            v = mk(2'd1, 1'b1, xr[16+k], xi[16+k]);
            v.ev = 1'b1;
            v.er = xr[k] + xr[16+k];
            v.ei = xi[k] + xi[16+k];
            v.eidx = 5'(k);
            vecs.push_back(v);
        end
        for (int k = 0; k < 16; k++) begin
            v = mk(2'd2, (k % 2) == 1, DW'($urandom), DW'($urandom));
            v.wr = DW'(twr(k));
            v.wi = DW'(twi(k));
            dr = xr[k] - xr[16+k];
            di = xi[k] - xi[16+k];
            sr = longint'($signed(dr));
            si = longint'($signed(di));
            lwr = longint'(twr(k));
            lwi = longint'(twi(k));
            ar = sr * lwr - si * lwi;
            ai = sr * lwi + si * lwr;
            v.ev = 1'b1;
            v.er = DW'(ar >>> 8);
            v.ei = DW'(ai >>> 8);
            v.eidx = 5'(16 + k);
            vecs.push_back(v);
        end
        for (int g = 0; g < 2; g++)
            vecs.push_back(mk(2'd3, 1'b1, DW'($urandom), DW'($urandom)));
    endtask

    task automatic run_vec(input vec_t v, input int id);
        state = v.st; in_valid = v.v;
        din_r = v.xr; din_i = v.xi;
        w_r = v.wr; w_i = v.wi;
        @(posedge clk);
        #1;
        chk("out_valid", id, 32'(out_valid), 32'(v.ev));
        if (v.ev) begin
            chk("dout_r", id, 32'(dout_r), 32'(v.er));
            chk("dout_i", id, 32'(dout_i), 32'(v.ei));
            chk("out_idx", id, 32'(out_idx), 32'(v.eidx));
        end
    endtask

    task automatic run_all(input int limit);
        int n;
        n = (limit < vecs.size()) ? limit : vecs.size();
        for (int i = 0; i < n; i++) run_vec(vecs[i], i);
        vecs.delete();
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout_r", 0, 32'(dout_r), 32'h0);
        chk("rst_dout_i", 0, 32'(dout_i), 32'h0);
        chk("rst_valid", 0, 32'(out_valid), 32'h0);
        chk("rst_idx", 0, 32'(out_idx), 32'h0);
        reset = 1'b0;

        // Impulse, constant, twiddle path, wrap, complex mix, then
        // stalled repeats that must match the no-gap expectations.
        add_frame(0, 1'b0);
        add_frame(1, 1'b0);
        add_frame(2, 1'b0);
        add_frame(3, 1'b0);
        add_frame(4, 1'b0);
        add_frame(2, 1'b1);
        add_frame(4, 1'b1);
        run_all(100000);

        // Asynchronous reset in the middle of a butterfly phase.
        add_frame(1, 1'b0);
        run_all(20);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 1, 32'(out_valid), 32'h0);
        chk("mid_rst_dout_r", 1, 32'(dout_r), 32'h0);
        chk("mid_rst_dout_i", 1, 32'(dout_i), 32'h0);
        chk("mid_rst_idx", 1, 32'(out_idx), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Head is zero after reset: a butterfly returns din unchanged.
        state = 2'd1; in_valid = 1'b1;
        din_r = 24'd100; din_i = 24'd7;
        @(posedge clk);
        #1;
        chk("post_rst_valid", 2, 32'(out_valid), 32'h1);
        chk("post_rst_r", 2, 32'(dout_r), 32'd100);
        chk("post_rst_i", 2, 32'(dout_i), 32'd7);
        chk("post_rst_idx", 2, 32'(out_idx), 32'h0);

        // Clean frame after the reset.
        add_frame(0, 1'b0);
        run_all(100000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
